// File: rtl/apb_master_slave.sv
// APB3 loopback subsystem: command/response master driving an internal
// APB bus, plus a small APB register-file slave on that bus.
module apb_master_slave #(
   parameter int NUM_REGS    = 4,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic        pready,
   output logic        pslverr,
   output logic [31:0] paddr,
   output logic [31:0] pwdata,
   output logic [31:0] prdata
);

   localparam int          IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [31:0] NREG = 32'(NUM_REGS);
   localparam logic [3:0]  WS   = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS
   } state_t;

   state_t        state;
   state_t        state_nx;

   logic          lat_write;
   logic [31:0]   lat_addr;
   logic [31:0]   lat_wdata;

   logic [3:0]    wait_cnt;
   logic [31:0]   regs [NUM_REGS];

   logic          accept;
   logic          access;
   logic          done;
   logic          addr_ok;
   logic [IW-1:0] idx;

   // master state register; reset (rst_n is active-high) aborts any transfer
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // master next-state and bus control decode
   always_comb begin
      state_nx  = state;
      cmd_ready = 1'b0;
      psel      = 1'b0;
      penable   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_nx = ST_SETUP;
            end
         end
         ST_SETUP: begin
            psel     = 1'b1;
            state_nx = ST_ACCESS;
         end
         ST_ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (pready) begin
               state_nx = ST_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   assign accept = cmd_valid && cmd_ready;

   // latch the accepted command; it drives the bus until the next accept
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (accept) begin
         lat_write <= cmd_write;
         lat_addr  <= cmd_addr;
         lat_wdata <= cmd_wdata;
      end
   end

   assign pwrite = lat_write;
   assign paddr  = lat_addr;
   assign pwdata = lat_wdata;

   assign access = psel && penable;
   assign pready = access && (wait_cnt == WS);
   assign done   = pready;

   // slave wait-state counter, counts stalled ACCESS cycles, else clears
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         wait_cnt <= '0;
      end else if (access && !pready) begin
         wait_cnt <= wait_cnt + 4'd1;
      end else begin
         wait_cnt <= '0;
      end
   end

   assign addr_ok = (paddr[1:0] == 2'b00) &&
                    ({2'b00, paddr[31:2]} < NREG);
   assign idx     = paddr[IW+1:2];

   assign prdata  = (access && addr_ok) ? regs[idx] : '0;
   assign pslverr = pready && !addr_ok;

   // register file; a write lands only on the completing ACCESS edge
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (done && pwrite && addr_ok) begin
         regs[idx] <= pwdata;
      end
   end

   // one-cycle response pulse following the completing ACCESS cycle
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= done;
         rsp_rdata <= (done && !pwrite) ? prdata : '0;
         rsp_err   <= done && pslverr;
      end
   end

endmodule

// File: tb/tb_apb_master_slave.sv
// Directed bench for apb_master_slave: zero and three wait-state
// instances, scoreboard of expected responses, reset-abort scenario.
module tb_apb_master_slave;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst_n;

   logic        cv   [2];
   logic        cw   [2];
   logic [31:0] ca   [2];
   logic [31:0] cd   [2];
   logic        crdy [2];
   logic        rv   [2];
   logic [31:0] rrd  [2];
   logic        re   [2];
   logic        ps   [2];
   logic        pen  [2];
   logic        pw   [2];
   logic        prdy [2];
   logic        perr [2];
   logic [31:0] pa   [2];
   logic [31:0] pwd  [2];
   logic [31:0] prd  [2];

   logic [31:0] mdl [2][4];
   exp_t        sb [$];
   longint      last_acc [2];

   int total;
   int fails;

   apb_master_slave #(.NUM_REGS(4), .WAIT_STATES(0)) u0 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cv[0]), .cmd_ready(crdy[0]),
      .cmd_write(cw[0]), .cmd_addr(ca[0]), .cmd_wdata(cd[0]),
      .rsp_valid(rv[0]), .rsp_rdata(rrd[0]), .rsp_err(re[0]),
      .psel(ps[0]), .penable(pen[0]), .pwrite(pw[0]),
      .pready(prdy[0]), .pslverr(perr[0]),
      .paddr(pa[0]), .pwdata(pwd[0]), .prdata(prd[0])
   );

   apb_master_slave #(.NUM_REGS(4), .WAIT_STATES(3)) u1 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cv[1]), .cmd_ready(crdy[1]),
      .cmd_write(cw[1]), .cmd_addr(ca[1]), .cmd_wdata(cd[1]),
      .rsp_valid(rv[1]), .rsp_rdata(rrd[1]), .rsp_err(re[1]),
      .psel(ps[1]), .penable(pen[1]), .pwrite(pw[1]),
      .pready(prdy[1]), .pslverr(perr[1]),
      .paddr(pa[1]), .pwdata(pwd[1]), .prdata(prd[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 4; i++)
            mdl[d][i] = '0;
   endtask

   // call at a falling edge; returns at the falling edge showing rsp_valid
   task automatic xfer(input int d, input logic w,
                       input logic [31:0] a, input logic [31:0] wd,
                       input string tag);
      exp_t        ex;
      exp_t        got;
      logic [29:0] ix;
      logic        vld;
      int          n;
      int          nacc;
      logic        seen;
      longint      t;
      ix  = a[31:2];
      vld = (a[1:0] == 2'b00) && (ix < 30'd4);
      ex.err   = !vld;
      ex.rdata = (!w && vld) ? mdl[d][ix[1:0]] : 32'h0;
      if (w && vld) mdl[d][ix[1:0]] = wd;
      sb.push_back(ex);
      cv[d] = 1'b1;
      cw[d] = w;
      ca[d] = a;
      cd[d] = wd;
      n = 0;
      while (!crdy[d] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready"}, 32'(crdy[d]), 32'd1);
      @(posedge clk);
      t = $time / 10;
      if (last_acc[d] >= 0)
         chk({tag, "_spacing_ge"},
             32'((t - last_acc[d]) >= longint'(3 + ws_of(d))), 32'd1);
      last_acc[d] = t;
      #1 cv[d] = 1'b0;
      @(negedge clk);
      chk({tag, "_setup"},
          32'({ps[d], pen[d], pw[d], crdy[d], prdy[d]}),
          32'({1'b1, 1'b0, w, 1'b0, 1'b0}));
      chk({tag, "_paddr"}, pa[d], a);
      nacc = 0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (rv[d]) seen = 1'b1;
         else if (pen[d]) nacc++;
      end
      chk({tag, "_rsp_seen"}, 32'(seen), 32'd1);
      chk({tag, "_access_cycles"}, 32'(nacc), 32'(ws_of(d) + 1));
      got.rdata = 32'hX;
      got.err   = 1'bX;
      if (sb.size() > 0) got = sb.pop_front();
      chk({tag, "_rdata"}, rrd[d], got.rdata);
      chk({tag, "_err"}, 32'(re[d]), 32'(got.err));
      chk({tag, "_hold"},
          32'({ps[d], pen[d], crdy[d], pa[d] == a, pwd[d] == wd}),
          32'b00111);
   endtask

   initial begin
      logic seen;
      total = 0;
      fails = 0;
      last_acc[0] = -1;
      last_acc[1] = -1;
      clear_model();
      for (int d = 0; d < 2; d++) begin
         cv[d] = 1'b0;
         cw[d] = 1'b0;
         ca[d] = '0;
         cd[d] = '0;
      end
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);

      chk("reset_ctrl",
          32'({crdy[0], ps[0], pen[0], pw[0], prdy[0], perr[0]}),
          32'b100000);
      chk("reset_rsp", 32'({rv[0], re[0], rrd[0] == 32'h0}), 32'b001);
      chk("reset_bus", pa[0] | pwd[0] | prd[0], 32'h0);
      chk("reset_u1",
          32'({crdy[1], ps[1], pen[1], rv[1]}), 32'b1000);

      xfer(0, 1'b1, 32'h0, 32'h00000006, "t1_wr0");
      xfer(0, 1'b0, 32'h0, 32'h0, "t1_rd0");

      xfer(0, 1'b1, 32'h4, 32'h32303233, "t2_wr4");
      xfer(0, 1'b0, 32'h4, 32'h0, "t2_rd4");
      xfer(0, 1'b0, 32'h0, 32'h0, "t2_rd0");

      xfer(0, 1'b1, 32'h8, 32'h37323632, "t3_wr8");
      xfer(0, 1'b1, 32'hC, 32'h37323646, "t3_wrc");
      xfer(0, 1'b0, 32'h8, 32'h0, "t3_rd8");
      xfer(0, 1'b0, 32'hC, 32'h0, "t3_rdc");

      xfer(0, 1'b0, 32'h10, 32'h0, "t4_rd10");
      xfer(0, 1'b1, 32'h6, 32'hFFFFFFFF, "t4_wr6");
      xfer(0, 1'b0, 32'h0, 32'h0, "t4_rd0");
      xfer(0, 1'b0, 32'h4, 32'h0, "t4_rd4");
      xfer(0, 1'b0, 32'h8, 32'h0, "t4_rd8");
      xfer(0, 1'b0, 32'hC, 32'h0, "t4_rdc");
      @(negedge clk);
      chk("t4_rsp_pulse", 32'(rv[0]), 32'd0);

      xfer(1, 1'b1, 32'h0, 32'hA5A55A5A, "t5_wr0");
      xfer(1, 1'b0, 32'h0, 32'h0, "t5_rd0");
      xfer(1, 1'b1, 32'h8, 32'h0BADF00D, "t5_wr8");
      xfer(1, 1'b0, 32'h8, 32'h0, "t5_rd8");
      xfer(1, 1'b0, 32'h20, 32'h0, "t5_rd20");

      cv[1] = 1'b1;
      cw[1] = 1'b1;
      ca[1] = 32'hC;
      cd[1] = 32'hCAFEF00D;
      @(posedge clk);
      #1 cv[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t6_in_access", 32'({ps[1], pen[1], prdy[1]}), 32'b110);
      #1 rst_n = 1'b1;
      #1 chk("t6_bus_idle",
             32'({ps[1], pen[1], crdy[1], rv[1]}), 32'b0010);
      @(negedge clk);
      rst_n = 1'b0;
      clear_model();
      last_acc[0] = -1;
      last_acc[1] = -1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rv[1]) seen = 1'b1;
      end
      chk("t6_no_rsp", 32'(seen), 32'd0);
      xfer(1, 1'b0, 32'hC, 32'h0, "t6_rdc");
      xfer(0, 1'b0, 32'h4, 32'h0, "t6_u0_rd4");

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
